// File: rtl/fetch_pc_unit_if.sv
// I-cache request/response bundle between the fetch unit and the cache.
// Master is the fetch side, slave is the cache side.
interface fetch_pc_unit_if #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
);
   logic              icache_req_valid_o;
   logic [ADDR_W-1:0] icache_req_addr_o;
   logic              icache_req_ready_i;
   logic              icache_resp_valid_i;
   logic [INST_W-1:0] icache_resp_data_i;

   modport master (
      output icache_req_valid_o,
      output icache_req_addr_o,
      input  icache_req_ready_i,
      input  icache_resp_valid_i,
      input  icache_resp_data_i
   );

   modport slave (
      input  icache_req_valid_o,
      input  icache_req_addr_o,
      output icache_req_ready_i,
      output icache_resp_valid_i,
      output icache_resp_data_i
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Credit-based instruction fetch front end with a PC-tagged
// instruction queue, stall, and redirect with in-flight drop.
module fetch_pc_unit #(
   parameter int                ADDR_W  = 64,
   parameter int                INST_W  = 32,
   parameter logic [ADDR_W-1:0] INIT_PC = 64'h8000_0000,
   parameter int                STEP    = 4,
   parameter int                DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ctrl_stall_i,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   fetch_pc_unit_if.master   icache,
   output logic              inst_valid_o,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   input  logic              inst_ready_i,
   output logic              protocol_err_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);
   localparam logic [ADDR_W-1:0] MASK = ~(ADDR_W'(STEP - 1));
   localparam logic [CW+1:0] LIMIT = (CW + 2)'(DEPTH);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] resp_pc;
   logic [ADDR_W-1:0] target;
   logic [CW-1:0]     outst;
   logic [CW-1:0]     drop_cnt;
   logic [CW-1:0]     count;
   logic [CW-1:0]     drop_redir;
   logic [CW+1:0]     used;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              hold;
   logic              err;
   logic              req_valid;
   logic              fire;
   logic              resp;
   logic              resp_drop;
   logic              push;
   logic              orphan;
   logic              pop;

   logic [INST_W-1:0] data_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];

   // Every slot in flight or queued holds one credit
   assign used = (CW + 2)'(outst) + (CW + 2)'(drop_cnt)
               + (CW + 2)'(count);

   assign req_valid = rst & (hold | (~ctrl_stall_i & (used < LIMIT)));
   assign fire      = req_valid & icache.icache_req_ready_i;

   assign resp      = rst & icache.icache_resp_valid_i;
   assign resp_drop = resp & (drop_cnt != '0);
   assign push      = resp & (drop_cnt == '0) & (outst != '0);
   assign orphan    = resp & (drop_cnt == '0) & (outst == '0);

   assign inst_valid_o = rst & ~redirect_valid_i & (count != '0);
   assign pop          = inst_valid_o & inst_ready_i;

   assign target = redirect_pc_i & MASK;

   // A response arriving with the redirect retires one in-flight slot
   assign drop_redir = drop_cnt + outst + CW'(fire)
                     - CW'(resp & ~orphan);

   assign icache.icache_req_valid_o = req_valid;
   assign icache.icache_req_addr_o  = fetch_pc;

   assign inst_o         = data_q[rd_ptr];
   assign inst_pc_o      = pc_q[rd_ptr];
   assign protocol_err_o = rst & err;

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc <= INIT_PC;
         resp_pc  <= INIT_PC;
         outst    <= '0;
         drop_cnt <= '0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         hold     <= 1'b0;
         err      <= 1'b0;
      end else if (redirect_valid_i) begin
         fetch_pc <= target;
         resp_pc  <= target;
         outst    <= '0;
         drop_cnt <= drop_redir;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         hold     <= 1'b0;
         if (orphan) err <= 1'b1;
      end else begin
         hold  <= req_valid & ~icache.icache_req_ready_i;
         outst <= outst + CW'(fire) - CW'(push);
         count <= count + CW'(push) - CW'(pop);
         if (fire) fetch_pc <= fetch_pc + STEP_A;
         if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
         if (push) begin
            resp_pc <= resp_pc + STEP_A;
            wr_ptr  <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (orphan) err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && !redirect_valid_i && push) begin
         data_q[wr_ptr] <= icache.icache_resp_data_i;
         pc_q[wr_ptr]   <= resp_pc;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: vector table plus
// hand-written sequences for credits, hold, redirect and errors.
module tb_fetch_pc_unit;

   localparam int ADDR_W = 64;
   localparam int INST_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall;
   logic              redir;
   logic [ADDR_W-1:0] rpc;
   logic              inst_valid;
   logic [INST_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;
   logic              inst_ready;
   logic              perr;

   int errors = 0;
   int checks = 0;
   int fires;
   logic prev;
   logic [63:0] faddr;

   fetch_pc_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) ic ();

   fetch_pc_unit #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W),
      .INIT_PC(64'h8000_0000),
      .STEP   (4),
      .DEPTH  (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .ctrl_stall_i    (stall),
      .redirect_valid_i(redir),
      .redirect_pc_i   (rpc),
      .icache          (ic),
      .inst_valid_o    (inst_valid),
      .inst_o          (inst),
      .inst_pc_o       (inst_pc),
      .inst_ready_i    (inst_ready),
      .protocol_err_o  (perr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        rdy;
      logic        rv;
      logic [31:0] rdata;
      logic        ir;
      logic        ev;
      logic [63:0] eaddr;
      logic        eiv;
      logic [63:0] epc;
      logic [31:0] einst;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic r,
                        input logic [63:0] p, input logic rdy,
                        input logic rv, input logic [31:0] rd,
                        input logic ir);
      stall                  = s;
      redir                  = r;
      rpc                    = p;
      ic.icache_req_ready_i  = rdy;
      ic.icache_resp_valid_i = rv;
      ic.icache_resp_data_i  = rd;
      inst_ready             = ir;
   endtask

   task automatic do_reset();
      drive(0, 0, 64'h0, 0, 0, 32'h0, 0);
      rst = 1'b0;
      #3;
      chk("rst_req_valid", ic.icache_req_valid_o, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_err", perr, 0);
      next();
      next();
      rst = 1'b1;
   endtask

   initial begin
      tbl[0] = '{0, 1, 0, 32'h0,  1, 1, 64'h8000_0000, 0, 64'h0, 32'h0};
      tbl[1] = '{0, 1, 1, 32'h11, 1, 1, 64'h8000_0004, 0, 64'h0, 32'h0};
      tbl[2] = '{0, 1, 1, 32'h22, 1, 1, 64'h8000_0008,
                 1, 64'h8000_0000, 32'h11};
      tbl[3] = '{0, 0, 1, 32'h33, 1, 1, 64'h8000_000C,
                 1, 64'h8000_0004, 32'h22};
      tbl[4] = '{1, 0, 0, 32'h0,  0, 1, 64'h8000_000C,
                 1, 64'h8000_0008, 32'h33};
      tbl[5] = '{1, 1, 0, 32'h0,  0, 1, 64'h8000_000C,
                 1, 64'h8000_0008, 32'h33};
      tbl[6] = '{1, 1, 1, 32'h44, 1, 0, 64'h8000_0010,
                 1, 64'h8000_0008, 32'h33};
      tbl[7] = '{0, 1, 0, 32'h0,  0, 1, 64'h8000_0010,
                 1, 64'h8000_000C, 32'h44};

      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].stall, 0, 64'h0, tbl[i].rdy, tbl[i].rv,
               tbl[i].rdata, tbl[i].ir);
         #3;
         chk($sformatf("vec%0d_req_valid", i),
             ic.icache_req_valid_o, tbl[i].ev);
         chk($sformatf("vec%0d_addr", i),
             ic.icache_req_addr_o, tbl[i].eaddr);
         chk($sformatf("vec%0d_inst_valid", i), inst_valid, tbl[i].eiv);
         if (tbl[i].eiv) begin
            chk($sformatf("vec%0d_pc", i), inst_pc, tbl[i].epc);
            chk($sformatf("vec%0d_inst", i), inst, tbl[i].einst);
         end
         chk($sformatf("vec%0d_err", i), perr, 0);
         next();
      end

      // Credit limit: decode never pops
      do_reset();
      fires = 0;
      prev  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 64'h0, 1, prev, 32'hA000_0000 + i, 0);
         #3;
         prev = ic.icache_req_valid_o & ic.icache_req_ready_i;
         if (prev) fires++;
         next();
      end
      chk("credit_fires", fires, 4);
      drive(0, 0, 64'h0, 1, 0, 32'h0, 1);
      #3;
      chk("credit_full_valid", ic.icache_req_valid_o, 0);
      chk("credit_head_valid", inst_valid, 1);
      chk("credit_head_pc", inst_pc, 64'h8000_0000);
      next();
      fires = 0;
      prev  = 1'b0;
      faddr = '0;
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 64'h0, 1, prev, 32'hB000_0000, 0);
         #3;
         if (i == 0) chk("credit_next_pc", inst_pc, 64'h8000_0004);
         prev = ic.icache_req_valid_o & ic.icache_req_ready_i;
         if (prev) begin
            fires++;
            faddr = ic.icache_req_addr_o;
         end
         next();
      end
      chk("credit_refill_fires", fires, 1);
      chk("credit_refill_addr", faddr, 64'h8000_0010);

      // Pending request held through stall
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(i != 0, 0, 64'h0, i == 3, 0, 32'h0, 0);
         #3;
         chk($sformatf("hold%0d_valid", i), ic.icache_req_valid_o, 1);
         chk($sformatf("hold%0d_addr", i),
             ic.icache_req_addr_o, 64'h8000_0000);
         next();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 64'h0, 1, 0, 32'h0, 0);
         #3;
         chk($sformatf("stall%0d_valid", i), ic.icache_req_valid_o, 0);
         next();
      end
      drive(0, 0, 64'h0, 1, 0, 32'h0, 0);
      #3;
      chk("unstall_valid", ic.icache_req_valid_o, 1);
      chk("unstall_addr", ic.icache_req_addr_o, 64'h8000_0004);
      next();

      // Redirect with three requests in flight
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 64'h0, 1, 0, 32'h0, 0);
         #3;
         chk($sformatf("pre_redir%0d_addr", i),
             ic.icache_req_addr_o, 64'h8000_0000 + 64'(4 * i));
         next();
      end
      drive(0, 1, 64'h8000_1002, 0, 0, 32'h0, 0);
      #3;
      chk("redir_inst_valid", inst_valid, 0);
      next();
      drive(0, 0, 64'h0, 1, 1, 32'hDEAD_0001, 1);
      #3;
      chk("redir_tgt_valid", ic.icache_req_valid_o, 1);
      chk("redir_tgt_addr", ic.icache_req_addr_o, 64'h8000_1000);
      next();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 64'h0, 0, 1,
               (i == 2) ? 32'h5555 : 32'hDEAD_0002 + i, 1);
         #3;
         chk($sformatf("redir_drop%0d_iv", i), inst_valid, 0);
         next();
      end
      drive(0, 0, 64'h0, 0, 0, 32'h0, 0);
      #3;
      chk("redir_first_valid", inst_valid, 1);
      chk("redir_first_pc", inst_pc, 64'h8000_1000);
      chk("redir_first_inst", inst, 32'h5555);
      next();

      // Redirect coinciding with a fire and a response
      do_reset();
      drive(0, 0, 64'h0, 1, 0, 32'h0, 0);
      next();
      drive(0, 1, 64'h100, 1, 1, 32'h0BAD_0000, 0);
      #3;
      chk("same_fire_valid", ic.icache_req_valid_o, 1);
      chk("same_fire_addr", ic.icache_req_addr_o, 64'h8000_0004);
      next();
      drive(0, 0, 64'h0, 0, 1, 32'h0BAD_0001, 0);
      #3;
      chk("same_tgt_addr", ic.icache_req_addr_o, 64'h100);
      next();
      drive(0, 0, 64'h0, 0, 0, 32'h0, 0);
      #3;
      chk("same_dropped_iv", inst_valid, 0);
      next();
      drive(0, 0, 64'h0, 1, 0, 32'h0, 0);
      #3;
      chk("same_refetch_addr", ic.icache_req_addr_o, 64'h100);
      next();
      drive(0, 0, 64'h0, 0, 1, 32'h77, 0);
      next();

      // Orphan response sets the sticky error
      drive(0, 0, 64'h0, 0, 1, 32'hEE, 0);
      #3;
      chk("orphan_pre_err", perr, 0);
      chk("orphan_pre_pc", inst_pc, 64'h100);
      next();
      drive(0, 0, 64'h0, 0, 0, 32'h0, 1);
      #3;
      chk("orphan_err", perr, 1);
      chk("orphan_iv", inst_valid, 1);
      chk("orphan_inst", inst, 32'h77);
      next();
      drive(0, 0, 64'h0, 0, 0, 32'h0, 0);
      #3;
      chk("orphan_q_empty", inst_valid, 0);
      chk("orphan_sticky", perr, 1);
      next();
      do_reset();
      #3;
      chk("err_cleared", perr, 0);

      // Address wrap at the top of the address space
      drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 32'h0, 0);
      next();
      drive(0, 0, 64'h0, 1, 0, 32'h0, 0);
      #3;
      chk("wrap_top_addr", ic.icache_req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
      next();
      drive(0, 0, 64'h0, 0, 0, 32'h0, 0);
      #3;
      chk("wrap_zero_valid", ic.icache_req_valid_o, 1);
      chk("wrap_zero_addr", ic.icache_req_addr_o, 64'h0);
      next();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Parametrised instruction-fetch front end; successor to the single-register PC generator.
- Issues sequential fetch requests to the I-cache over a valid/ready handshake and tracks outstanding requests with credits.
- Buffers in-order cache responses in an instruction queue, tagged with their PC, for the decode stage.
- Supports stall, and branch redirect with flush and drop of in-flight responses.

Parameters:
- ADDR_W, 64, address width.
- INST_W, 32, instruction width.
- INIT_PC, 64'h80000000, first fetch address after reset.
- STEP, 4, PC increment; power of two.
- DEPTH, 4, instruction queue entries; also the total credit limit. Power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- ctrl_stall_i  in  1  block issue of new fetch requests.
- redirect_valid_i  in  1  branch redirect this cycle.
- redirect_pc_i  in  ADDR_W  redirect target.
- icache_req_valid_o  out  1  fetch request valid.
- icache_req_addr_o  out  ADDR_W  fetch address.
- icache_req_ready_i  in  1  cache accepts request.
- icache_resp_valid_i  in  1  in-order response valid; no backpressure.
- icache_resp_data_i  in  INST_W  fetched instruction.
- inst_valid_o  out  1  queue head valid.
- inst_o  out  INST_W  head instruction.
- inst_pc_o  out  ADDR_W  head PC.
- inst_ready_i  in  1  decode pops head.
- protocol_err_o  out  1  sticky unexpected-response flag.

Behaviour:
- Reset (rst=0 at a clk edge):
  - fetch_pc=INIT_PC, resp_pc=INIT_PC.
  - outstanding=0, drop_cnt=0, queue count=0, hold=0.
  - icache_req_valid_o=0, inst_valid_o=0, protocol_err_o=0.
  - All outputs are forced to these values while rst=0.
  - Reset mid-operation discards all state; later responses to pre-reset requests are not protected against, and the cache is reset with this unit.
- Credits:
  - used = outstanding + drop_cnt + count.
  - Invariant: used ≤ DEPTH.
  - Counters are clog2(DEPTH+1) bits wide.
- Request:
  - icache_req_valid_o = hold | (~ctrl_stall_i & used<DEPTH).
  - icache_req_addr_o = fetch_pc.
  - hold sets when valid is high and ready is low; it clears on fire.
  - Once asserted, valid and addr stay stable until fire; stall does not withdraw a pending request.
  - Fire (valid&ready): fetch_pc += STEP, modulo 2^ADDR_W; outstanding++.
- Response, when icache_resp_valid_i=1:
  - If drop_cnt>0: discard the response; drop_cnt--.
  - Else if outstanding>0: push {resp_pc, data}; resp_pc += STEP; outstanding--.
  - Else: ignore the response and set protocol_err_o, sticky until reset.
- Queue:
  - Circular buffer of DEPTH entries; head is presented combinationally.
  - inst_valid_o = count>0.
  - Pop on inst_valid_o & inst_ready_i.
  - Push and pop in the same cycle leave count unchanged.
  - Push when count==DEPTH is impossible by the credit rule.
  - Pointers wrap modulo DEPTH.
- Latency:
  - Request fires in cycle N; response arrives in cycle M ≥ N+1.
  - inst_valid_o is high in cycle M+1 if the queue was empty.
- Redirect, when redirect_valid_i=1 in cycle R; it has priority over everything else:
  - target = redirect_pc_i with its low log2(STEP) bits cleared.
  - fetch_pc ← target and resp_pc ← target.
  - Queue is flushed, count=0; inst_valid_o is forced 0 in cycle R and any pop in R is ignored.
  - drop_cnt ← drop_cnt + outstanding + fire_R − resp_R, where fire_R and resp_R are 1 if a request fires or a response arrives in R.
  - The response in R is dropped; outstanding ← 0.
  - hold clears in R. A request firing in R used the old address and is counted for drop.
  - From R+1, requests issue at target, subject to stall and credits.
- Back-to-back redirects accumulate drop_cnt; the credit rule bounds it to DEPTH.
- Stall together with redirect: state updates as above, and no new request issues until stall drops.

Test Plan:
- Reset release, ready=1, no stall, 1-cycle cache: addresses 0x80000000, 0x80000004, 0x80000008 fire on consecutive cycles → inst_pc_o follows the same sequence with the matching data; protocol_err_o=0.
- inst_ready_i=0, responses always returned → exactly 4 requests fire (DEPTH=4), then icache_req_valid_o=0 while count=4. Raising ready for 1 cycle pops 0x80000000 and allows exactly 1 new request.
- ready=0 for 3 cycles with valid high, stall raised in the 2nd cycle → addr stays 0x80000000 and valid stays high until fire; after fire, no further requests until stall drops.
- 3 outstanding, then redirect to 0x80001002 → next request addr is 0x80001000. The 3 late responses are dropped, and the first inst_pc_o after the redirect is 0x80001000.
- Redirect in the same cycle as a fire and a response, with outstanding=1 → drop_cnt=1 in the next cycle; exactly one further response is discarded.
- Response with outstanding=0 and drop_cnt=0 → protocol_err_o=1 from the next cycle, held until rst=0; the queue is unchanged.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC fires → next addr is 0x0.
